// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data ports onto one single-port memory; grants are combinational, read data returns 1 cycle after grant.
// Data port has default priority; fetch is forced through after STARVE_MAX consecutive losses. No-grant holds the requester stalled.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       force_if;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        state_nxt  = IDLE;
        starve_nxt = starve_cnt;
        force_if   = (starve_cnt == STARVE_LIM);

        // Grants are held off entirely while reset is asserted.
        if (rst) begin
            if_gnt = if_req && (!d_req || force_if);
            d_gnt  = d_req && !if_gnt;
        end

        if (if_gnt)
            mem_addr = if_addr;
        else if (d_gnt)
            mem_addr = d_addr;

        if (d_gnt)
            mem_wdata = d_wdata;

        if (if_gnt)
            state_nxt = RESP_IF;
        else if (d_gnt && !d_we)
            state_nxt = RESP_D;

        if (!if_req || if_gnt)
            starve_nxt = '0;
        else if (d_gnt && starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
    end

    assign mem_en   = if_gnt | d_gnt;
    assign mem_we   = d_gnt & d_we;
    assign if_stall = if_req & ~if_gnt;

    // A response pending when reset arrives is dropped rather than delivered.
    assign if_rvalid = rst && (state == RESP_IF);
    assign d_rvalid  = rst && (state == RESP_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a queue-based scoreboard and a behavioural memory.
module tb_mem_port_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_stall;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          ig, dg, en, we, st;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          dv;
        logic [DW-1:0] dd;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;

    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] dev_mem[int];

    // Reference-model state: consecutive fetch losses and the read owed next cycle.
    int            losses = 0;
    logic          pend_iv = 1'b0;
    logic          pend_dv = 1'b0;
    logic [DW-1:0] pend_data = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    // Memory device: read data one cycle after a read access, junk otherwise.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we)
                mem_rdata <= dev_mem.exists(int'(mem_addr)) ? dev_mem[int'(mem_addr)] : init_val(mem_addr);
            else
                mem_rdata <= 16'($urandom);
            if (mem_en && mem_we)
                dev_mem[int'(mem_addr)] = mem_wdata;
        end
    end

    task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, output logic gi, output logic gd);
        rexp_t re;
        gexp_t ge;
        @(posedge clk);
        #1;
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;

        re = '0;
        if (r) begin
            re.iv = pend_iv;
            re.dv = pend_dv;
            if (pend_iv) re.id = pend_data;
            if (pend_dv) re.dd = pend_data;
        end
        rq.push_back(re);

        gi = r && ir && (!dr || losses == SMAX);
        gd = r && dr && !gi;
        ge.ig   = gi;
        ge.dg   = gd;
        ge.en   = gi || gd;
        ge.we   = gd && dw;
        ge.st   = ir && !gi;
        ge.addr = gi ? ia : (gd ? da : '0);
        ge.wd   = gd ? dd : '0;
        gq.push_back(ge);

        pend_iv   = gi;
        pend_dv   = gd && !dw;
        pend_data = gi ? ref_rd(ia) : ref_rd(da);
        if (gd && dw) ref_mem[int'(da)] = dd;
        if (!r || !ir || gi) losses = 0;
        else if (gd && losses < SMAX) losses++;
    endtask

    // Monitor: compares every cycle's grant/memory outputs and responses against the queues.
    initial begin
        gexp_t g, ga;
        rexp_t e, ra;
        forever begin
            @(negedge clk);
            if (gq.size() > 0) begin
                g  = gq.pop_front();
                ga = {if_gnt, d_gnt, mem_en, mem_we, if_stall, mem_addr, mem_wdata};
                checks++;
                if (ga !== g) begin
                    errors++;
                    $display("FAIL grant @%0t: got {ig,dg,en,we,st,addr,wd}=%b%b%b%b%b %h %h, expected %b%b%b%b%b %h %h",
                             $time, ga.ig, ga.dg, ga.en, ga.we, ga.st, ga.addr, ga.wd,
                             g.ig, g.dg, g.en, g.we, g.st, g.addr, g.wd);
                end
            end
            if (rq.size() > 0) begin
                e  = rq.pop_front();
                ra = {if_rvalid, if_rdata, d_rvalid, d_rdata};
                checks++;
                if (ra !== e) begin
                    errors++;
                    $display("FAIL resp @%0t: got if %b/%h d %b/%h, expected if %b/%h d %b/%h",
                             $time, ra.iv, ra.id, ra.dv, ra.dd, e.iv, e.id, e.dv, e.dd);
                end
            end
        end
    end

    initial begin
        logic          gi, gd;
        logic          pi, pd, pdw;
        logic [AW-1:0] pia, pda;
        logic [DW-1:0] pdd;
        logic          r;

        // Reset with random request activity: no grants, stall follows if_req.
        repeat (3) step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                        16'($urandom), 16'($urandom), gi, gd);

        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hA5A5, gi, gd);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0300, 16'h1234, gi, gd);
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);

        // Collision: data wins, fetch stalls, fetch granted the following cycle.
        step(1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0200, 16'h0, gi, gd);
        step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);

        // Sustained contention: D,D,D,IF,D,D.
        repeat (6) step(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0300, 16'h0, gi, gd);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);

        // Alternating fetch and data reads with no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step(1'b1, 1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
            else
                step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'(16'h0300 + i), 16'h0, gi, gd);
        end

        // Randomized traffic: requests held until granted, occasional drops and resets.
        pi = 1'b0; pd = 1'b0; pdw = 1'b0; pia = '0; pda = '0; pdd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1'b1; pia = 16'($urandom_range(0, 31));
            end else if (pi && $urandom_range(0, 15) == 0) begin
                pi = 1'b0;
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1'b1; pdw = 1'($urandom); pda = 16'($urandom_range(0, 31));
                pdd = 16'($urandom);
            end else if (pd && $urandom_range(0, 15) == 0) begin
                pd = 1'b0;
            end
            r = ($urandom_range(0, 99) != 0);
            step(r, pi, pi ? pia : 16'($urandom), pd, pdw, pd ? pda : 16'($urandom),
                 pd ? pdd : 16'($urandom), gi, gd);
            if (gi) pi = 1'b0;
            if (gd) pd = 1'b0;
        end

        // Reset right after a data read grant, with partial starvation built up first.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
        repeat (2) step(1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0208, 16'h0, gi, gd);
        step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0208, 16'h0, gi, gd);
        step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0208, 16'h7777, gi, gd);
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
        repeat (5) step(1'b1, 1'b1, 16'h0024, 1'b1, 1'b0, 16'h020C, 16'h0, gi, gd);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);

        repeat (3) @(posedge clk);
        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d grant and %0d response expectations left, expected 0",
                     gq.size(), rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
